// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one N-bit adder (no carry-in/out) among NREQ requesters.
// Subtraction is done in two adder passes: a + ~b, then +1.
module adder_share_ctrl #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [N-1:0]      a_q, b_q, res;
  logic              sub_q;
  logic [ID_W-1:0]   id_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  int unsigned       idx;

  logic [N-1:0]      add_a, add_b, sum;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_found)
      req_ready[grant_id] = 1'b1;
  end

  // Operand mux into the single shared adder.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      PASS1: begin
        add_a = a_q;
        add_b = sub_q ? ~b_q : b_q;
      end
      PASS2: begin
        add_a = res;
        add_b = N'(1);
      end
      default: ;
    endcase
  end

  assign sum = add_a + add_b;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = PASS1;
      PASS1:   state_nxt = sub_q ? PASS2 : DONE;
      PASS2:   state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      id_q   <= '0;
      res    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_found) begin
        a_q    <= req_a[32'(grant_id)*N +: N];
        b_q    <= req_b[32'(grant_id)*N +: N];
        sub_q  <= req_sub[grant_id];
        id_q   <= grant_id;
        rr_ptr <= ID_W'((32'(grant_id) + 1) % NREQ);
      end
      if (state == PASS1 || state == PASS2)
        res <= sum;
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_data  = res;
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: add/sub latency, wrap cases, round-robin order,
// response backpressure and reset during an in-flight subtract.
module tb_adder_share_ctrl;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              busy;

  int passed = 0;
  int total  = 0;

  adder_share_ctrl #(.N(N), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Single requester op; entered and left at posedge+1 with the block in IDLE.
  task automatic do_op(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] exp);
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_sub[id]      = sub;
    req_valid        = onehot(id);
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(onehot(id)));
    tick;
    req_valid = '0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_early1"}, 32'(rsp_valid), 32'd0);
    if (sub) begin
      tick;
      chk({tag, "_early2"}, 32'(rsp_valid), 32'd0);
    end
    tick;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    tick;
    rst_n = 1'b1;
    tick;

    do_op("t1_add", 0, 32'd5, 32'd7, 1'b0, 32'd12);
    do_op("t2_sub", 2, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE);
    do_op("t3_wrapadd", 1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    do_op("t3_minsub", 0, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF);
    do_op("t3_zerosub", 3, 32'd0, 32'd0, 1'b1, 32'd0);

    // rr_ptr is back at 0: all requesters valid, one add completes every 3 cycles.
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 32'(i * 16 + 1);
      req_b[i*N +: N] = 32'(i);
      req_sub[i]      = 1'b0;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t4_grant", 32'(req_ready), 32'(onehot(k % NREQ)));
      tick;
      chk("t4_pass1", 32'(req_ready), 32'd0);
      tick;
      chk("t4_valid", 32'(rsp_valid), 32'd1);
      chk("t4_id", 32'(rsp_id), 32'(k % NREQ));
      chk("t4_data", rsp_data, 32'((k % NREQ) * 17 + 1));
      tick;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    tick;
    chk("t4_idle", 32'(busy), 32'd0);

    // rr_ptr = 2: hold a response while req1 waits.
    req_a[2*N +: N] = 32'd10;
    req_b[2*N +: N] = 32'd20;
    req_sub[2]      = 1'b0;
    req_valid       = 4'b0100;
    #1;
    chk("t5_grant2", 32'(req_ready), 32'b0100);
    tick;
    req_valid       = 4'b0010;
    req_a[1*N +: N] = 32'd100;
    req_b[1*N +: N] = 32'd1;
    req_sub[1]      = 1'b0;
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_data", rsp_data, 32'd30);
      chk("t5_hold_id", 32'(rsp_id), 32'd2);
      chk("t5_hold_ready", 32'(req_ready), 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("t5_released", 32'(rsp_valid), 32'd0);
    chk("t5_grant1", 32'(req_ready), 32'b0010);
    tick;
    req_valid = '0;
    tick;
    chk("t5_data1", rsp_data, 32'd101);
    chk("t5_id1", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // Reset lands while req3's subtract is in PASS2.
    req_a[3*N +: N] = 32'd50;
    req_b[3*N +: N] = 32'd8;
    req_sub[3]      = 1'b1;
    req_valid       = 4'b1000;
    #1;
    chk("t6_grant3", 32'(req_ready), 32'b1000);
    tick;
    req_valid = '0;
    tick;
    chk("t6_pass2_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req_a[0*N +: N] = 32'd1;
    req_b[0*N +: N] = 32'd2;
    req_sub[0]      = 1'b0;
    req_valid       = 4'b1001;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("t6_grant0", 32'(req_ready), 32'b0001);
    tick;
    req_valid = 4'b1000;
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    tick;
    chk("t6_valid", 32'(rsp_valid), 32'd1);
    chk("t6_data", rsp_data, 32'd3);
    chk("t6_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    #1;
    chk("t6_next3", 32'(req_ready), 32'b1000);
    req_valid = '0;
    tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
